ld_st_unit: RTL and testbench

- Memory-access unit that consumes the 3-bit load/store control code produced by instruction decode and executes it against the data memory port.
- Store path: generates word address, byte-write mask and lane-replicated write data.
- Load path: selects, sign/zero-extends and returns read data with its destination register tag.
- Sits between the execute stage and the data memory. The processor stalls on req_ready=0.

---
 rtl/ld_st_unit_if.sv | 49 ++++
 rtl/ld_st_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_ld_st_unit.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ld_st_unit_if.sv
// Bus bundles for the load/store unit: the execute-side request/response
// channel and the data-memory port.

interface ld_st_req_if #(
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        ld_st_ctrl;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       store_data;
    logic [TAG_W-1:0]  rd_tag;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic [TAG_W-1:0]  resp_rd;
    logic              misalign;

    modport master (
        output req_valid, ld_st_ctrl, addr, store_data, rd_tag,
        input  req_ready, resp_valid, resp_data, resp_rd, misalign
    );

    modport slave (
        input  req_valid, ld_st_ctrl, addr, store_data, rd_tag,
        output req_ready, resp_valid, resp_data, resp_rd, misalign
    );
endinterface

interface ld_st_mem_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-3:0] mem_addr;
    logic              mem_re;
    logic [3:0]        mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_addr, mem_re, mem_we, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_re, mem_we, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/ld_st_unit.sv
// Load/store unit: executes decoded load/store codes against a big-endian
// word-addressed data memory with byte-lane masks and load extension.

module ld_st_unit #(
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    ld_st_req_if.slave    req_if,
    ld_st_mem_if.master   mem_if
);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    function automatic logic is_store(input logic [2:0] ctrl);
        return (ctrl == OP_SB) || (ctrl == OP_SH) || (ctrl == OP_SW);
    endfunction

    function automatic logic is_aligned(input logic [2:0] ctrl, input logic [1:0] off);
        logic ok;
        case (ctrl)
            OP_LH, OP_LHU, OP_SH: ok = (off[0] == 1'b0);
            OP_LW, OP_SW:         ok = (off == 2'b00);
            default:              ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Byte-enable bit 3 is the lowest byte address (big-endian lane order).
    function automatic logic [3:0] store_mask(input logic [2:0] ctrl, input logic [1:0] off);
        logic [3:0] m;
        case (ctrl)
            OP_SB:   m = 4'b1000 >> off;
            OP_SH:   m = off[1] ? 4'b0011 : 4'b1100;
            OP_SW:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] ctrl, input logic [31:0] sd);
        logic [31:0] w;
        case (ctrl)
            OP_SB:   w = {4{sd[7:0]}};
            OP_SH:   w = {2{sd[15:0]}};
            OP_SW:   w = sd;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] ctrl, input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = rdata[31:24];
            2'd1:    b = rdata[23:16];
            2'd2:    b = rdata[15:8];
            2'd3:    b = rdata[7:0];
            default: b = 8'h00;
        endcase
        h = off[1] ? rdata[15:0] : rdata[31:16];
        case (ctrl)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LW:   r = rdata;
            OP_LBU:  r = {24'h00_0000, b};
            OP_LHU:  r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic [1:0]        off_q, off_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              req_ready_q, req_ready_d;
    logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
    logic              mem_re_q, mem_re_d;
    logic [3:0]        mem_we_q, mem_we_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic [TAG_W-1:0]  resp_rd_q, resp_rd_d;
    logic              misalign_q, misalign_d;
    logic              hs_s;
    logic              aligned_s;

    assign hs_s      = req_if.req_valid & req_ready_q;
    assign aligned_s = is_aligned(req_if.ld_st_ctrl, req_if.addr[1:0]);

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ctrl_q       <= 3'b000;
            off_q        <= 2'b00;
            tag_q        <= '0;
            req_ready_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 4'b0000;
            mem_wdata_q  <= 32'h0000_0000;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'h0000_0000;
            resp_rd_q    <= '0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctrl_q       <= ctrl_d;
            off_q        <= off_d;
            tag_q        <= tag_d;
            req_ready_q  <= req_ready_d;
            mem_addr_q   <= mem_addr_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_rd_q    <= resp_rd_d;
            misalign_q   <= misalign_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (hs_s && aligned_s) begin
                    state_d = S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (mem_if.mem_ack) begin
                    state_d = is_store(ctrl_q) ? S_IDLE : S_RESP;
                end else begin
                    state_d = S_ACCESS;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the latched request and of every registered output.
    always_comb begin
        ctrl_d       = ctrl_q;
        off_d        = off_q;
        tag_d        = tag_q;
        mem_addr_d   = mem_addr_q;
        resp_data_d  = resp_data_q;
        req_ready_d  = 1'b0;
        mem_re_d     = 1'b0;
        mem_we_d     = 4'b0000;
        mem_wdata_d  = 32'h0000_0000;
        resp_valid_d = 1'b0;
        resp_rd_d    = '0;
        misalign_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hs_s && aligned_s) begin
                    ctrl_d      = req_if.ld_st_ctrl;
                    off_d       = req_if.addr[1:0];
                    tag_d       = req_if.rd_tag;
                    mem_addr_d  = req_if.addr[ADDR_W-1:2];
                    mem_re_d    = !is_store(req_if.ld_st_ctrl);
                    mem_we_d    = store_mask(req_if.ld_st_ctrl, req_if.addr[1:0]);
                    mem_wdata_d = store_lanes(req_if.ld_st_ctrl, req_if.store_data);
                    req_ready_d = 1'b0;
                end else if (hs_s) begin
                    misalign_d  = 1'b1;
                    req_ready_d = 1'b1;
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            S_ACCESS: begin
                if (mem_if.mem_ack) begin
                    // A store frees the unit immediately; a load still owes its response cycle.
                    req_ready_d = is_store(ctrl_q);
                    if (!is_store(ctrl_q)) begin
                        resp_valid_d = 1'b1;
                        resp_rd_d    = tag_q;
                        resp_data_d  = load_extend(ctrl_q, off_q, mem_if.mem_rdata);
                    end else begin
                        resp_valid_d = 1'b0;
                    end
                end else begin
                    mem_re_d    = mem_re_q;
                    mem_we_d    = mem_we_q;
                    mem_wdata_d = mem_wdata_q;
                end
            end
            S_RESP:  req_ready_d = 1'b1;
            default: req_ready_d = 1'b0;
        endcase
    end

    assign req_if.req_ready  = req_ready_q;
    assign req_if.resp_valid = resp_valid_q;
    assign req_if.resp_data  = resp_data_q;
    assign req_if.resp_rd    = resp_rd_q;
    assign req_if.misalign   = misalign_q;
    assign mem_if.mem_addr   = mem_addr_q;
    assign mem_if.mem_re     = mem_re_q;
    assign mem_if.mem_we     = mem_we_q;
    assign mem_if.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_ld_st_unit.sv
// Self-checking bench for ld_st_unit: a delayed-ack memory responder and a
// load-response scoreboard, driven by directed load/store/misalign/reset cases.

module tb_ld_st_unit;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          ack_delay = 1;
    int          wcnt = 0;
    logic [31:0] rd_val = 32'h0000_0000;
    exp_t        sb_q[$];

    ld_st_req_if #(.ADDR_W(32), .TAG_W(5)) rq();
    ld_st_mem_if #(.ADDR_W(32))            mm();

    ld_st_unit #(.ADDR_W(32), .TAG_W(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_if (rq),
        .mem_if (mm)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Memory model: acks after ack_delay cycles of active strobes.
    initial begin
        mm.mem_ack   = 1'b0;
        mm.mem_rdata = 32'h0000_0000;
        forever begin
            @(posedge clk);
            #1;
            if (mm.mem_re || (mm.mem_we != 4'b0000)) begin
                wcnt++;
                mm.mem_ack   = (wcnt == ack_delay);
                mm.mem_rdata = (wcnt == ack_delay) ? rd_val : 32'h0000_0000;
            end else begin
                wcnt         = 0;
                mm.mem_ack   = 1'b0;
                mm.mem_rdata = 32'h0000_0000;
            end
        end
    end

    // Response monitor and strobe-exclusivity watch.
    always @(negedge clk) begin
        exp_t e;
        if (rq.resp_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_resp", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("resp_data", rq.resp_data, e.data);
                check_eq("resp_rd", 32'(rq.resp_rd), 32'(e.tag));
            end
        end
        if (mm.mem_re && (mm.mem_we != 4'b0000)) begin
            check_eq("re_we_excl", 32'd1, 32'd0);
        end
    end

    // Waits for req_ready, then holds one handshake; returns at cycle 1 of the request.
    task automatic issue(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] tag);
        int n = 0;
        while (!rq.req_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check_eq("ready_timeout", 32'd0, 32'd1);
        rq.req_valid  = 1'b1;
        rq.ld_st_ctrl = ctrl;
        rq.addr       = a;
        rq.store_data = sd;
        rq.rd_tag     = tag;
        @(posedge clk);
        #1;
        rq.req_valid  = 1'b0;
    endtask

    task automatic wait_resp(input int exp_cycle);
        int n = 1;
        while (!rq.resp_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("resp_latency", 32'(n), 32'(exp_cycle));
        check_eq("resp_ready_low", 32'(rq.req_ready), 32'd0);
        @(posedge clk);
        #1;
        check_eq("resp_single", 32'(rq.resp_valid), 32'd0);
    endtask

    task automatic do_load(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] rdata,
                           input logic [31:0] exp_data, input logic [4:0] tag, input int dly);
        rd_val    = rdata;
        ack_delay = dly;
        sb_q.push_back('{data: exp_data, tag: tag});
        issue(ctrl, a, 32'h0000_0000, tag);
        check_eq("ld_re", 32'(mm.mem_re), 32'd1);
        check_eq("ld_we", 32'(mm.mem_we), 32'd0);
        check_eq("ld_addr", 32'(mm.mem_addr), {2'b00, a[31:2]});
        wait_resp(dly + 1);
    endtask

    task automatic do_store(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] sd,
                            input logic [3:0] exp_we, input logic [31:0] exp_wd, input int dly);
        int n = 1;
        ack_delay = dly;
        issue(ctrl, a, sd, 5'd0);
        check_eq("st_we", 32'(mm.mem_we), 32'(exp_we));
        check_eq("st_wdata", mm.mem_wdata, exp_wd);
        check_eq("st_re", 32'(mm.mem_re), 32'd0);
        check_eq("st_addr", 32'(mm.mem_addr), {2'b00, a[31:2]});
        while ((mm.mem_we != 4'b0000) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("st_drop", 32'(n), 32'(dly + 1));
        check_eq("st_ready", 32'(rq.req_ready), 32'd1);
    endtask

    initial begin
        rq.req_valid  = 1'b0;
        rq.ld_st_ctrl = 3'b000;
        rq.addr       = 32'h0000_0000;
        rq.store_data = 32'h0000_0000;
        rq.rd_tag     = 5'd0;
        rst_n         = 1'b0;
        #3;
        check_eq("rst_ready", 32'(rq.req_ready), 32'd0);
        check_eq("rst_re", 32'(mm.mem_re), 32'd0);
        check_eq("rst_we", 32'(mm.mem_we), 32'd0);
        check_eq("rst_resp", 32'(rq.resp_valid), 32'd0);
        check_eq("rst_misalign", 32'(rq.misalign), 32'd0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_ready", 32'(rq.req_ready), 32'd1);

        do_load(OP_LB,  32'h0000_1003, 32'h1122_3380, 32'hFFFF_FF80, 5'd7,  1);
        do_load(OP_LBU, 32'h0000_1003, 32'h1122_3380, 32'h0000_0080, 5'd12, 1);
        do_load(OP_LHU, 32'h0000_1002, 32'hAAAA_8001, 32'h0000_8001, 5'd31, 2);
        do_load(OP_LH,  32'h0000_1000, 32'h8001_1234, 32'hFFFF_8001, 5'd4,  1);
        do_load(OP_LB,  32'h0000_1001, 32'h117F_3380, 32'h0000_007F, 5'd2,  3);

        do_store(OP_SB, 32'h0000_2002, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB, 2);
        do_store(OP_SH, 32'h0000_3000, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 1);
        do_store(OP_SH, 32'h0000_3002, 32'h1234_5678, 4'b0011, 32'h5678_5678, 1);
        do_store(OP_SW, 32'h0000_4000, 32'h1234_5678, 4'b1111, 32'h1234_5678, 1);

        // Five wait states with an ignored store request mid-wait.
        rd_val    = 32'hDEAD_BEEF;
        ack_delay = 5;
        sb_q.push_back('{data: 32'hDEAD_BEEF, tag: 5'd3});
        issue(OP_LW, 32'h0000_1004, 32'h0000_0000, 5'd3);
        for (int c = 1; c <= 5; c++) begin
            check_eq("ws_re", 32'(mm.mem_re), 32'd1);
            check_eq("ws_addr", 32'(mm.mem_addr), 32'h0000_0401);
            check_eq("ws_ready", 32'(rq.req_ready), 32'd0);
            if (c == 3) begin
                rq.req_valid  = 1'b1;
                rq.ld_st_ctrl = OP_SB;
                rq.addr       = 32'h0000_2000;
                rq.store_data = 32'h0000_0055;
            end else begin
                rq.req_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        rq.req_valid = 1'b0;
        check_eq("ws_resp", 32'(rq.resp_valid), 32'd1);
        @(posedge clk);
        #1;
        check_eq("ws_single", 32'(rq.resp_valid), 32'd0);
        check_eq("ws_no_store", 32'(mm.mem_we), 32'd0);
        check_eq("ws_idle_re", 32'(mm.mem_re), 32'd0);

        // Misaligned requests back to back, then an aligned load.
        issue(OP_LW, 32'h0000_1002, 32'h0000_0000, 5'd1);
        check_eq("mis_lw", 32'(rq.misalign), 32'd1);
        check_eq("mis_lw_re", 32'(mm.mem_re), 32'd0);
        check_eq("mis_lw_we", 32'(mm.mem_we), 32'd0);
        check_eq("mis_lw_ready", 32'(rq.req_ready), 32'd1);
        issue(OP_SH, 32'h0000_1001, 32'h0000_BEEF, 5'd1);
        check_eq("mis_sh", 32'(rq.misalign), 32'd1);
        check_eq("mis_sh_we", 32'(mm.mem_we), 32'd0);
        check_eq("mis_sh_re", 32'(mm.mem_re), 32'd0);
        do_load(OP_LW, 32'h0000_1008, 32'h0BAD_F00D, 32'h0BAD_F00D, 5'd8, 1);
        check_eq("mis_cleared", 32'(rq.misalign), 32'd0);

        // Asynchronous reset in the middle of an access.
        ack_delay = 100;
        issue(OP_LW, 32'h0000_1010, 32'h0000_0000, 5'd6);
        check_eq("ar_re_before", 32'(mm.mem_re), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_re", 32'(mm.mem_re), 32'd0);
        check_eq("ar_ready", 32'(rq.req_ready), 32'd0);
        check_eq("ar_addr", 32'(mm.mem_addr), 32'd0);
        #14;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_eq("ar_no_resp", 32'(rq.resp_valid), 32'd0);
        end
        do_load(OP_LW, 32'h0000_1014, 32'hCAFE_F00D, 32'hCAFE_F00D, 5'd9, 2);

        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
